// File: rtl/fp_sqrt_pkg.sv
// rtl/fp_sqrt_pkg.sv - shared types and constants for the sequential single-precision square root
package fp_sqrt_pkg;

    localparam int ITER   = 25;
    localparam int BIAS   = 127;
    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int RAD_W  = 2 * ITER;
    localparam int REM_W  = ITER + 2;

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_ROUND,
        ST_DONE
    } state_e;

endpackage

// File: rtl/fp_sqrt_step.sv
// rtl/fp_sqrt_step.sv - one restoring square-root iteration (combinational)
module fp_sqrt_step
    import fp_sqrt_pkg::*;
(
    input  logic [REM_W-1:0] rem_in,
    input  logic [ITER-1:0]  root_in,
    input  logic [1:0]       rad_bits,
    output logic [REM_W-1:0] rem_out,
    output logic [ITER-1:0]  root_out
);

    logic [REM_W+1:0] cur;
    logic [REM_W+1:0] trial;
    logic [REM_W+1:0] diff;
    logic             unused_bits;

    always_comb begin
        cur   = {rem_in, rad_bits};
        trial = {2'b00, root_in, 2'b01};
        diff  = cur - trial;
        if (cur >= trial) begin
            rem_out  = diff[REM_W-1:0];
            root_out = {root_in[ITER-2:0], 1'b1};
        end else begin
            rem_out  = cur[REM_W-1:0];
            root_out = {root_in[ITER-2:0], 1'b0};
        end
    end

    // The remainder never exceeds twice the root, so the top bits stay zero.
    assign unused_bits = ^{cur[REM_W+1:REM_W], diff[REM_W+1:REM_W], root_in[ITER-1]};

endmodule

// File: rtl/fp_sqrt_seq.sv
// rtl/fp_sqrt_seq.sv - sequential IEEE-754 single square root, one root bit per cycle
module fp_sqrt_seq
    import fp_sqrt_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        Exception,
    output logic        Underflow,
    output logic        Overflow
);

    state_e             state_q, state_d;
    logic [31:0]        res_q, res_d;
    logic [2:0]         flags_q, flags_d;
    logic [RAD_W-1:0]   rad_q, rad_d;
    logic [REM_W-1:0]   rem_q, rem_d;
    logic [ITER-1:0]    root_q, root_d;
    logic [4:0]         cnt_q, cnt_d;
    logic [EXP_W-1:0]   exp_q, exp_d;

    logic               sign;
    logic [EXP_W-1:0]   e_in;
    logic [FRAC_W-1:0]  f_in;
    logic               is_special;
    logic [31:0]        spec_res;
    logic [2:0]         spec_flags;
    logic               odd_exp;
    logic [ITER-1:0]    sig_ext;
    logic [EXP_W:0]     exp_sum;
    logic [REM_W-1:0]   step_rem;
    logic [ITER-1:0]    step_root;
    logic               rnd_up;
    logic [ITER-1:0]    sig_rnd;
    logic               carry;
    logic               unused_bits;

    assign {sign, e_in, f_in} = a;

    // Flags are packed {Exception, Underflow, Overflow}; the first matching rule wins.
    always_comb begin
        is_special = 1'b1;
        spec_res   = QNAN;
        spec_flags = 3'b100;
        if (e_in == '1 && f_in != '0) begin
            spec_res   = QNAN;
        end else if (sign && e_in != '0) begin
            spec_res   = QNAN;
        end else if (e_in == '1) begin
            spec_res   = POS_INF;
            spec_flags = 3'b001;
        end else if (e_in == '0 && f_in == '0) begin
            spec_res   = a;
            spec_flags = 3'b000;
        end else if (e_in == '0) begin
            spec_res   = {sign, 31'd0};
            spec_flags = 3'b010;
        end else begin
            is_special = 1'b0;
        end
    end

    // An even biased exponent means an odd unbiased one; halving (E+BIAS-odd) is exact.
    assign odd_exp = ~e_in[0];
    assign sig_ext = odd_exp ? {1'b1, f_in, 1'b0} : {2'b01, f_in};
    assign exp_sum = {1'b0, e_in} + (EXP_W+1)'(BIAS) - {{EXP_W{1'b0}}, odd_exp};

    fp_sqrt_step u_step (
        .rem_in   (rem_q),
        .root_in  (root_q),
        .rad_bits (rad_q[RAD_W-1 -: 2]),
        .rem_out  (step_rem),
        .root_out (step_root)
    );

    assign rnd_up  = root_q[0] & ((|rem_q) | root_q[1]);
    assign sig_rnd = {1'b0, root_q[ITER-1:1]} + {{(ITER-1){1'b0}}, rnd_up};
    assign carry   = sig_rnd[ITER-1];
    assign unused_bits = ^{exp_sum[0], sig_rnd[FRAC_W]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            res_q   <= '0;
            flags_q <= '0;
            rad_q   <= '0;
            rem_q   <= '0;
            root_q  <= '0;
            cnt_q   <= '0;
            exp_q   <= '0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            flags_q <= flags_d;
            rad_q   <= rad_d;
            rem_q   <= rem_d;
            root_q  <= root_d;
            cnt_q   <= cnt_d;
            exp_q   <= exp_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (in_valid) state_d = is_special ? ST_DONE : ST_CALC;
            ST_CALC:  if (cnt_q == 5'(ITER-1)) state_d = ST_ROUND;
            ST_ROUND: state_d = ST_DONE;
            ST_DONE:  if (out_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        res_d   = res_q;
        flags_d = flags_q;
        rad_d   = rad_q;
        rem_d   = rem_q;
        root_d  = root_q;
        cnt_d   = cnt_q;
        exp_d   = exp_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && is_special) begin
                    res_d   = spec_res;
                    flags_d = spec_flags;
                end else if (in_valid) begin
                    rad_d  = {sig_ext, {ITER{1'b0}}};
                    rem_d  = '0;
                    root_d = '0;
                    cnt_d  = '0;
                    exp_d  = exp_sum[EXP_W:1];
                end
            end
            ST_CALC: begin
                rem_d  = step_rem;
                root_d = step_root;
                rad_d  = {rad_q[RAD_W-3:0], 2'b00};
                cnt_d  = cnt_q + 5'd1;
            end
            ST_ROUND: begin
                res_d   = {1'b0, exp_q + {{(EXP_W-1){1'b0}}, carry},
                           carry ? {FRAC_W{1'b0}} : sig_rnd[FRAC_W-1:0]};
                flags_d = 3'b000;
            end
            default: ;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_DONE);
    end

    assign result    = res_q;
    assign Exception = flags_q[2];
    assign Underflow = flags_q[1];
    assign Overflow  = flags_q[0];

endmodule

// File: tb/tb_fp_sqrt_seq.sv
// tb/tb_fp_sqrt_seq.sv - self-checking bench for fp_sqrt_seq
module tb_fp_sqrt_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        exc, unf, ovf;

    int n_cmp = 0;
    int n_bad = 0;

    fp_sqrt_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .Exception (exc),
        .Underflow (unf),
        .Overflow  (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    function automatic longint isqrt(input longint n);
        longint lo = 0, hi = 64'd1 << 31, mid;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (mid * mid <= n) lo = mid;
            else hi = mid;
        end
        return lo;
    endfunction

    // Reference: exact integer square root of the scaled value, then round-to-nearest-even.
    task automatic ref_sqrt(input logic [31:0] x, output logic [31:0] r, output logic [2:0] fl);
        int      ex, e, p, sh, ef;
        longint  m, n, rt, sig, remv, half;
        logic    exact, up;
        ex = int'(x[30:23]);
        fl = 3'b000;
        if (ex == 255 && x[22:0] != 0)      begin r = 32'h7FC00000; fl = 3'b100; end
        else if (x[31] && ex != 0)          begin r = 32'h7FC00000; fl = 3'b100; end
        else if (ex == 255)                 begin r = 32'h7F800000; fl = 3'b001; end
        else if (ex == 0 && x[22:0] == 0)   begin r = x; end
        else if (ex == 0)                   begin r = {x[31], 31'd0}; fl = 3'b010; end
        else begin
            m = longint'({1'b1, x[22:0]});
            e = ex - 150;
            if ((e % 2) != 0) begin m = m * 2; e = e - 1; end
            n  = m << 36;
            rt = isqrt(n);
            p = 0;
            for (int i = 0; i < 63; i++) if (rt >= (64'd1 << i)) p = i;
            sh    = p - 23;
            sig   = rt >> sh;
            remv  = rt & ((64'd1 << sh) - 1);
            half  = 64'd1 << (sh - 1);
            exact = (rt * rt == n);
            up    = (remv > half) || (remv == half && (!exact || sig[0]));
            sig   = sig + (up ? 1 : 0);
            ef    = p + e / 2 - 18 + 127;
            if (sig == (64'd1 << 24)) begin sig = sig >> 1; ef = ef + 1; end
            r = {1'b0, 8'(ef), 23'(sig)};
        end
    endtask

    // Presents op, waits for its result with out_ready high; lat counts edges after acceptance.
    task automatic run_op(input logic [31:0] op, output logic [31:0] r, output logic [2:0] fl,
                          output int lat, output logic rdy_after);
        int g = 0;
        while (!in_ready && g < 200) begin @(posedge clk); #1; g++; end
        if (!in_ready) check("idle_timeout", 32'(in_ready), 32'd1);
        a = op; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = $urandom;
        lat = 1;
        while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        if (!out_valid) check("result_timeout", 32'(out_valid), 32'd1);
        r  = result;
        fl = {exc, unf, ovf};
        @(posedge clk); #1;
        rdy_after = in_ready && !out_valid;
    endtask

    typedef struct {
        logic [31:0] op;
        logic [31:0] res;
        logic [2:0]  fl;
        int          lat;
    } vec_t;

    vec_t        vecs[10];
    logic [31:0] r, er, ops[4];
    logic [2:0]  fl, efl;
    int          lat, nres, last, idx, seen;
    logic        rdy, acc;

    initial begin
        vecs[0] = '{32'h41800000, 32'h40800000, 3'b000, 27};
        vecs[1] = '{32'h43100000, 32'h41400000, 3'b000, 27};
        vecs[2] = '{32'h3E800000, 32'h3F000000, 3'b000, 27};
        vecs[3] = '{32'h40000000, 32'h3FB504F3, 3'b000, 27};
        vecs[4] = '{32'h3F800000, 32'h3F800000, 3'b000, 27};
        vecs[5] = '{32'hC1800000, 32'h7FC00000, 3'b100, 1};
        vecs[6] = '{32'h7FC00001, 32'h7FC00000, 3'b100, 1};
        vecs[7] = '{32'h7F800000, 32'h7F800000, 3'b001, 1};
        vecs[8] = '{32'h00000001, 32'h00000000, 3'b010, 1};
        vecs[9] = '{32'h80000000, 32'h80000000, 3'b000, 1};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_result", result, 32'h0);
        check("reset_flags", 32'({exc, unf, ovf}), 32'h0);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].op, r, fl, lat, rdy);
            check($sformatf("vec%0d_result", i), r, vecs[i].res);
            check($sformatf("vec%0d_flags", i), 32'(fl), 32'(vecs[i].fl));
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("vec%0d_ready_after", i), 32'(rdy), 32'd1);
        end

        for (int i = 0; i < 60; i++) begin
            logic [31:0] x;
            case ($urandom_range(0, 9))
                0: x = {1'b1, 8'($urandom_range(1, 254)), 23'($urandom)};
                1: x = {1'b0, 8'd0, 23'($urandom_range(1, 8388607))};
                2: x = {1'b0, 8'd255, 23'($urandom_range(0, 3))};
                default: x = {1'b0, 8'($urandom_range(1, 254)), 23'($urandom)};
            endcase
            ref_sqrt(x, er, efl);
            run_op(x, r, fl, lat, rdy);
            check($sformatf("rand%0d_result(a=%08h)", i, x), r, er);
            check($sformatf("rand%0d_flags(a=%08h)", i, x), 32'(fl), 32'(efl));
        end

        // Backpressure: result must hold and a second operand must be refused.
        out_ready = 1'b0;
        a = 32'h41800000; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        check("bp_latency", 32'(lat), 32'd27);
        a = 32'h40800000; in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_result", result, 32'h40800000);
            check("bp_hold_flags", 32'({exc, unf, ovf}), 32'h0);
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        check("bp_release_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        check("bp_second_not_taken", 32'(in_ready), 32'd1);

        // Reset in the middle of an iteration discards the operation.
        a = 32'h41800000; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_out_valid", 32'(out_valid), 32'd0);
        check("rst_mid_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("rst_mid_no_output", 32'(seen), 32'd0);
        run_op(32'h40800000, r, fl, lat, rdy);
        check("rst_after_result", r, 32'h40000000);
        check("rst_after_flags", 32'(fl), 32'h0);

        // Back-to-back with in_valid held high.
        ops[0] = 32'h41800000; ops[1] = 32'h40000000; ops[2] = 32'h43100000; ops[3] = 32'h3E800000;
        idx = 0; nres = 0; last = -1;
        a = ops[0]; in_valid = 1'b1; out_ready = 1'b1;
        for (int cyc = 0; cyc < 300 && nres < 4; cyc++) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            if (out_valid) begin
                ref_sqrt(ops[nres], er, efl);
                check($sformatf("b2b%0d_result", nres), result, er);
                check($sformatf("b2b%0d_flags", nres), 32'({exc, unf, ovf}), 32'(efl));
                if (nres > 0) check($sformatf("b2b%0d_spacing", nres), 32'(cyc - last), 32'd28);
                last = cyc;
                nres++;
            end
            @(posedge clk); #1;
            if (acc) begin
                idx++;
                if (idx < 4) a = ops[idx];
                else in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        check("b2b_count", 32'(nres), 32'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
